// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register-bank responder: NUM_REGS x 32-bit registers, flat reg_out export.
// Optional macro AXIL_SLAVE_ID_REG_EN makes register 0 a read-only ID register (ID_VALUE).
module axi4lite_reg_slave #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] ID_VALUE   = 32'hA41C_0001
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     WVALID,
    output logic                     WREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    input  logic [2:0]               ARPROT,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic [32*NUM_REGS-1:0]   reg_out
);

    localparam int             IDX_W      = ADDR_WIDTH - 2;
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]     RESP_OKAY  = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    logic [31:0]      regs     [NUM_REGS];
    logic [31:0]      reg_view [NUM_REGS];

    logic             aw_held;
    logic             w_held;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;

    logic             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data, rd_data;
    logic [3:0]       wr_strb;
    logic             wr_commit, wr_ok, rd_in_range;

    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
    // READY never waits on VALID, and every output VALID holds with its payload until its READY.
    assign AWREADY = ARESETn & ~aw_held & ~BVALID;
    assign WREADY  = ARESETn & ~w_held  & ~BVALID;
    assign ARREADY = ARESETn & ~RVALID;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID  & WREADY;
    assign ar_hs = ARVALID & ARREADY;

    // A channel arriving this edge is used directly, so AW+W together commit immediately.
    assign wr_idx    = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
    assign wr_data   = w_held  ? w_data_q : WDATA;
    assign wr_strb   = w_held  ? w_strb_q : WSTRB;
    assign wr_commit = (aw_held | aw_hs) & (w_held | w_hs);

`ifdef AXIL_SLAVE_ID_REG_EN
    assign wr_ok = ({1'b0, wr_idx} < NUM_REGS_W) & (wr_idx != '0);
`else
    assign wr_ok = ({1'b0, wr_idx} < NUM_REGS_W);
`endif

    assign rd_idx      = ARADDR[ADDR_WIDTH-1:2];
    assign rd_in_range = ({1'b0, rd_idx} < NUM_REGS_W);

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_view[k] = regs[k];
        end
`ifdef AXIL_SLAVE_ID_REG_EN
        reg_view[0] = ID_VALUE;
`endif
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_data = reg_view[k];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_ok && (wr_idx == IDX_W'(k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            regs[k][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    // Read data is taken from the pre-edge register view, so a same-edge write is not seen.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_in_range ? rd_data : 32'h0;
            RRESP  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out[32*k +: 32] = reg_view[k];
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Scoreboard bench for axi4lite_reg_slave: directed cases plus randomized traffic
// checked against an array model of the register bank.
module tb_axi4lite_reg_slave;

    localparam int          AW = 8;
    localparam int          NR = 16;
    localparam logic [31:0] IDV = 32'hA41C_0001;

    logic             ACLK, ARESETn;
    logic             AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic             ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0]    AWADDR, ARADDR;
    logic [2:0]       AWPROT, ARPROT;
    logic [31:0]      WDATA, RDATA;
    logic [3:0]       WSTRB;
    logic [1:0]       BRESP, RRESP;
    logic [32*NR-1:0] reg_out;

    axi4lite_reg_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .ID_VALUE(IDV)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .reg_out(reg_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];
    logic [31:0] model [NR];
    logic        rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] model_view(input int k);
`ifdef AXIL_SLAVE_ID_REG_EN
        if (k == 0) return IDV;
`endif
        return model[k];
    endfunction

    function automatic logic [33:0] exp_read(input logic [AW-1:0] addr);
        int idx = int'(addr) / 4;
        if (idx >= NR) return {2'b10, 32'h0};
        return {2'b00, model_view(idx)};
    endfunction

    // Applies a committed write to the model and queues its expected response.
    task automatic model_write_push(input logic [AW-1:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb);
        int idx = int'(addr) / 4;
        bit ok = (idx < NR);
`ifdef AXIL_SLAVE_ID_REG_EN
        if (idx == 0) ok = 1'b0;
`endif
        if (ok) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
            b_exp_q.push_back(2'b00);
        end else begin
            b_exp_q.push_back(2'b10);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s reg_out[%0d]", tag, k), 64'(reg_out[32*k +: 32]), 64'(model_view(k)));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [AW-1:0] addr);
        int n = 0;
        logic rdy;
        AWVALID = 1'b1; AWADDR = addr; AWPROT = 3'($urandom_range(0, 7));
        do begin
            rdy = AWREADY;
            @(posedge ACLK); #1;
            n++;
        end while (!rdy && n < 200);
        AWVALID = 1'b0;
        if (!rdy) timeout_fail("aw_handshake");
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        logic rdy;
        WVALID = 1'b1; WDATA = data; WSTRB = strb;
        do begin
            rdy = WREADY;
            @(posedge ACLK); #1;
            n++;
        end while (!rdy && n < 200);
        WVALID = 1'b0;
        if (!rdy) timeout_fail("w_handshake");
    endtask

    task automatic send_ar(input logic [AW-1:0] addr);
        int n = 0;
        logic rdy;
        ARVALID = 1'b1; ARADDR = addr; ARPROT = 3'($urandom_range(0, 7));
        do begin
            rdy = ARREADY;
            @(posedge ACLK); #1;
            n++;
        end while (!rdy && n < 200);
        ARVALID = 1'b0;
        if (!rdy) timeout_fail("ar_handshake");
    endtask

    task automatic write_txn(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        fork
            begin
                repeat (aw_dly) begin @(posedge ACLK); #1; end
                send_aw(addr);
            end
            begin
                repeat (w_dly) begin @(posedge ACLK); #1; end
                send_w(data, strb);
            end
        join
        model_write_push(addr, data, strb);
    endtask

    task automatic read_txn(input logic [AW-1:0] addr);
        send_ar(addr);
        r_exp_q.push_back(exp_read(addr));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && n < 500) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 500) timeout_fail("drain_responses");
        @(posedge ACLK); #1;
    endtask

    // ---------------- random ready generator ----------------
    initial begin
        forever begin
            @(posedge ACLK); #1;
            if (rand_rdy) begin
                BREADY = 1'($urandom_range(0, 1));
                RREADY = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitor ----------------
    logic        r_stall = 1'b0;
    logic        b_stall = 1'b0;
    logic [33:0] r_prev;
    logic [1:0]  b_prev;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall) check("r_hold_stable", {31'h0, RVALID, RRESP, RDATA}, {31'h0, 1'b1, r_prev});
            if (b_stall) check("b_hold_stable", {61'h0, BVALID, BRESP}, {61'h0, 1'b1, b_prev});
            if (RVALID) check("arready_low_while_rvalid", 64'(ARREADY), 64'(0));
            if (BVALID) check("aw_w_ready_low_while_bvalid", 64'({AWREADY, WREADY}), 64'(0));
            if (BVALID && BREADY) begin
                if (b_exp_q.size() == 0) timeout_fail("unexpected_b_response");
                else check("bresp", 64'(BRESP), 64'(b_exp_q.pop_front()));
            end
            if (RVALID && RREADY) begin
                if (r_exp_q.size() == 0) timeout_fail("unexpected_r_response");
                else check("rresp_rdata", 64'({RRESP, RDATA}), 64'(r_exp_q.pop_front()));
            end
            r_stall = RVALID && !RREADY;
            b_stall = BVALID && !BREADY;
            r_prev  = {RRESP, RDATA};
            b_prev  = BRESP;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] addr;
        ARESETn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
        WVALID = 1'b0; WDATA = '0; WSTRB = '0;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = '0;
        BREADY = 1'b1; RREADY = 1'b1;
        foreach (model[k]) model[k] = 32'h0;

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
        check("rst_valids", 64'({BVALID, RVALID}), 64'(0));
        check_regs("rst");
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("post_rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));

        // reset in the middle of a write with AW held
        write_txn(8'h04, 32'hCAFE_F00D, 4'hF, 0, 0);
        wait_idle();
        send_aw(8'h10);
        check("aw_held_blocks_awready", 64'(AWREADY), 64'(0));
        #2 ARESETn = 1'b0;
        #1;
        foreach (model[k]) model[k] = 32'h0;
        check("midrst_bvalid", 64'(BVALID), 64'(0));
        check("midrst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
        check_regs("midrst");
        @(negedge ACLK) ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("midrst_release_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
        send_w(32'h1234_5678, 4'hF);
        repeat (4) begin
            @(posedge ACLK); #1;
            check("no_b_for_discarded_aw", 64'(BVALID), 64'(0));
        end
        send_aw(8'h14);
        model_write_push(8'h14, 32'h1234_5678, 4'hF);
        wait_idle();

        // same-cycle AW/W, then read back
        write_txn(8'h08, 32'hDEAD_BEEF, 4'hF, 0, 0);
        check("same_cycle_b", 64'({BVALID, BRESP}), 64'({1'b1, 2'b00}));
        read_txn(8'h08);
        wait_idle();

        // W ahead of AW with partial strobes
        write_txn(8'h0C, 32'h1122_3344, 4'hF, 0, 0);
        write_txn(8'h0C, 32'hAABB_CCDD, 4'b0101, 3, 0);
        check("strobe_merge_reg3", 64'(reg_out[3*32 +: 32]), 64'(32'h11BB_33DD));
        wait_idle();

        // out-of-range write and read
        write_txn(8'h40, 32'h1, 4'hF, 0, 0);
        check("oor_b", 64'({BVALID, BRESP}), 64'({1'b1, 2'b10}));
        read_txn(8'h44);
        wait_idle();
        check_regs("after_oor");

        // R back-pressure
        RREADY = 1'b0;
        read_txn(8'h0C);
        repeat (5) begin
            @(posedge ACLK); #1;
            check("bp_rvalid_rdata", 64'({RVALID, ARREADY, RDATA}), 64'({1'b1, 1'b0, model_view(3)}));
        end
        RREADY = 1'b1;
        wait_idle();

        // read samples reg 2 on the edge a write commits there
        write_txn(8'h08, 32'h9, 4'hF, 0, 0);
        wait_idle();
        r_exp_q.push_back({2'b00, 32'h9});
        fork
            send_ar(8'h08);
            write_txn(8'h08, 32'h5, 4'hF, 0, 0);
        join
        check("collision_reg2_new", 64'(reg_out[2*32 +: 32]), 64'(32'h5));
        wait_idle();

`ifdef AXIL_SLAVE_ID_REG_EN
        read_txn(8'h00);
        write_txn(8'h00, 32'h0BAD_0BAD, 4'hF, 0, 0);
        check("id_write_slverr", 64'({BVALID, BRESP}), 64'({1'b1, 2'b10}));
        read_txn(8'h00);
        wait_idle();
`endif

        // randomized traffic with random ready back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            addr = AW'($urandom_range(0, (NR + 4) * 4 - 1));
            if ($urandom_range(0, 1) == 1) begin
                write_txn(addr, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                read_txn(addr);
            end
        end
        rand_rdy = 1'b0;
        BREADY = 1'b1;
        RREADY = 1'b1;
        wait_idle();
        check_regs("final");
        check("leftover_expected", 64'(b_exp_q.size() + r_exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
